brick_mem_ctrl: RTL and testbench
=================================

# brick_mem_ctrl

Controller and arbiter for the brick health RAM: a single-port, 2-bit-wide synchronous memory with one brick per word. It sequences level initialisation (it fills every brick with a starting health) and shares the RAM between two requesters. The ball-collision logic issues read-modify-write "hit" transactions; the renderer issues read-only "draw" transactions. It also maintains the count of bricks remaining and raises level-clear.

## Interface
Parameters:
- GRID_W, 8, bricks per row
- GRID_H, 4, rows of bricks
- COL_W, 3, column index width
- ROW_W, 2, row index width
- ADDR_W, 5, RAM address width; address = row*GRID_W + col
- INIT_HEALTH, 3, health written at level start; legal range 1..3

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- level_start  in  1  one-cycle pulse, (re)initialise all bricks
- init_busy  out  1  high while the fill is in progress
- init_done  out  1  one-cycle pulse when the fill completes
- hit_req  in  1  collision request, held high until hit_ack
- hit_col / hit_row  in  COL_W / ROW_W  brick hit
- hit_ack  out  1  one-cycle pulse, hit result valid
- hit_valid  out  1  brick had health>0 before the hit
- hit_health  out  2  health after the hit
- draw_req  in  1  render read request, held high until draw_ack
- draw_col / draw_row  in  COL_W / ROW_W  brick to read
- draw_ack  out  1  one-cycle pulse, draw_health valid
- draw_health  out  2  health read; held until the next draw_ack
- mem_addr  out  ADDR_W  RAM address
- mem_data  out  2  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  2  RAM read data; valid one cycle after the address is presented
- bricks_left  out  ADDR_W+1  count of bricks with health>0
- level_clear  out  1  high when bricks_left==0 after at least one completed init

## Operation
- FSM states: IDLE, INIT, HIT_RD, HIT_CHK, HIT_WR, DRAW_RD, DRAW_CHK.
- IDLE arbitration: pending init > hit_req > draw_req. Requests are sampled only in IDLE, and only in a cycle where neither hit_ack nor draw_ack is high (ack holdoff).
- level_start sets init_pending in any state. It is consumed on entry to INIT. An in-flight hit or draw completes first.
- INIT: a counter walks addresses 0..GRID_W*GRID_H-1, one per cycle, with mem_wren=1 and mem_data=INIT_HEALTH. After the last write: return to IDLE, pulse init_done, load bricks_left=GRID_W*GRID_H, set the initialised flag.
- HIT_RD presents the address. In HIT_CHK, mem_q is valid and is registered as old.
- HIT_WR drives mem_wren=1 with mem_data=old-1 only if old!=0. If old==0, mem_wren=0.
- On leaving HIT_WR: hit_ack=1, hit_valid=(old!=0), hit_health=(old!=0 ? old-1 : 0). If old==1, bricks_left decrements.
- DRAW_RD presents the address. At the end of DRAW_CHK, draw_health<=mem_q and draw_ack pulses.
- Out-of-range col>=GRID_W or row>=GRID_H: the transaction runs all its states but the read value is forced to 0. There is no write. The results are hit_valid=0 and draw_health=0.
- The health decrement saturates at 0 and never wraps.
- bricks_left never underflows.

## Timing
- Reset values: state IDLE, all outputs 0 (including bricks_left, level_clear, mem_* and every ack/pulse), init_pending=0, initialised flag=0.
- Reset mid-transaction aborts the transaction immediately. No ack is produced.
- Hit latency: request accepted at edge E0. HIT_RD runs in cycle 1, HIT_CHK in cycle 2, HIT_WR (write) in cycle 3. hit_ack is high in cycle 4.
- Draw latency: request accepted at edge E0. DRAW_RD runs in cycle 1, DRAW_CHK in cycle 2. draw_ack is high in cycle 3.
- Init: the first write is in the cycle after level_start is accepted, followed by N consecutive write cycles (N=GRID_W*GRID_H). init_busy is high for exactly those N cycles. init_done is high in cycle N+1.
- Requesters must drop req in their ack cycle. Holdoff prevents double acceptance.
- Back-to-back throughput: one hit every 5 cycles, or one draw every 4 cycles.
- level_clear is combinational from registered state: bricks_left==0 && initialised && !init_busy.

## Test plan
- Reset, then level_start (defaults) -> mem_wren high for 32 consecutive cycles at addresses 0..31 with data 3; init_done 1 cycle later; bricks_left=32; level_clear=0.
- hit (col 2, row 1) three times -> mem_addr=10 each time; hit_health 2, 1, 0; hit_valid=1 each time; bricks_left=31 after the third hit. A fourth hit gives hit_valid=0 and no mem_wren.
- hit_req and draw_req raised in the same cycle -> hit_ack in cycle 4; the draw is accepted after holdoff; draw_ack carries the post-hit health.
- level_start pulsed during HIT_CHK -> the hit completes with ack, then INIT starts; the hit is never lost or repeated.
- draw with col=9 -> draw_ack with draw_health=0, no write.
- 32 bricks hit to 0 -> bricks_left=0, level_clear=1. Async reset asserted mid-INIT -> all outputs 0 immediately, no init_done.

Source files
------------

// File: rtl/brick_mem_ctrl_if.sv
// Bus bundle for the brick health RAM controller: level control, the hit and
// draw request/ack channels, the single-port RAM connection and the status.
interface brick_mem_ctrl_if #(
    parameter int COL_W  = 3,
    parameter int ROW_W  = 2,
    parameter int ADDR_W = 5
);
    logic              level_start;
    logic              init_busy;
    logic              init_done;

    logic              hit_req;
    logic [COL_W-1:0]  hit_col;
    logic [ROW_W-1:0]  hit_row;
    logic              hit_ack;
    logic              hit_valid;
    logic [1:0]        hit_health;

    logic              draw_req;
    logic [COL_W-1:0]  draw_col;
    logic [ROW_W-1:0]  draw_row;
    logic              draw_ack;
    logic [1:0]        draw_health;

    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data;
    logic              mem_wren;
    logic [1:0]        mem_q;

    logic [ADDR_W:0]   bricks_left;
    logic              level_clear;

    // Controller side
    modport slave (
        input  level_start, hit_req, hit_col, hit_row,
               draw_req, draw_col, draw_row, mem_q,
        output init_busy, init_done, hit_ack, hit_valid, hit_health,
               draw_ack, draw_health, mem_addr, mem_data, mem_wren,
               bricks_left, level_clear
    );

    // Requester / RAM side
    modport master (
        output level_start, hit_req, hit_col, hit_row,
               draw_req, draw_col, draw_row, mem_q,
        input  init_busy, init_done, hit_ack, hit_valid, hit_health,
               draw_ack, draw_health, mem_addr, mem_data, mem_wren,
               bricks_left, level_clear
    );
endinterface

// File: rtl/brick_mem_ctrl.sv
// Brick health RAM controller: fills the RAM at level start, arbitrates
// read-modify-write hits and read-only draws, and tracks bricks remaining.
module brick_mem_ctrl #(
    parameter int GRID_W      = 8,
    parameter int GRID_H      = 4,
    parameter int COL_W       = 3,
    parameter int ROW_W       = 2,
    parameter int ADDR_W      = 5,
    parameter int INIT_HEALTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    brick_mem_ctrl_if.slave  bus
);

    localparam int                NUM_BRICKS = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_BRICKS - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(NUM_BRICKS);
    localparam logic [1:0]        INIT_VAL   = 2'(INIT_HEALTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_HIT_RD   = 3'd2;
    localparam logic [2:0] S_HIT_CHK  = 3'd3;
    localparam logic [2:0] S_HIT_WR   = 3'd4;
    localparam logic [2:0] S_DRAW_RD  = 3'd5;
    localparam logic [2:0] S_DRAW_CHK = 3'd6;

    // Health decrement that stops at zero instead of wrapping to 3.
    function automatic logic [1:0] sat_dec(input logic [1:0] h);
        return (h == 2'd0) ? 2'd0 : h - 2'd1;
    endfunction

    function automatic logic [ADDR_W-1:0] brick_addr(input logic [COL_W-1:0] c,
                                                     input logic [ROW_W-1:0] r);
        return ADDR_W'(int'(r) * GRID_W + int'(c));
    endfunction

    function automatic logic brick_in_range(input logic [COL_W-1:0] c,
                                            input logic [ROW_W-1:0] r);
        return (int'(c) < GRID_W) && (int'(r) < GRID_H);
    endfunction

    logic [2:0]        state_q,        state_d;
    logic              init_pending_q, init_pending_d;
    logic              initialised_q,  initialised_d;
    logic [ADDR_W-1:0] init_cnt_q,     init_cnt_d;
    logic [ADDR_W-1:0] addr_q,         addr_d;
    logic              in_range_q,     in_range_d;
    logic [1:0]        old_q,          old_d;
    logic              hit_ack_q,      hit_ack_d;
    logic              hit_valid_q,    hit_valid_d;
    logic [1:0]        hit_health_q,   hit_health_d;
    logic              draw_ack_q,     draw_ack_d;
    logic [1:0]        draw_health_q,  draw_health_d;
    logic              init_done_q,    init_done_d;
    logic [ADDR_W:0]   bricks_left_q,  bricks_left_d;

    logic [ADDR_W-1:0] mem_addr_c;
    logic [1:0]        mem_data_c;
    logic              mem_wren_c;
    logic              holdoff;

    // A requester still sees its ack this cycle, so its req may still be high.
    assign holdoff = hit_ack_q | draw_ack_q;

    // Next-state, RAM drive and result computation.
    always_comb begin
        state_d        = state_q;
        init_pending_d = init_pending_q | bus.level_start;
        initialised_d  = initialised_q;
        init_cnt_d     = init_cnt_q;
        addr_d         = addr_q;
        in_range_d     = in_range_q;
        old_d          = old_q;
        hit_ack_d      = 1'b0;
        hit_valid_d    = hit_valid_q;
        hit_health_d   = hit_health_q;
        draw_ack_d     = 1'b0;
        draw_health_d  = draw_health_q;
        init_done_d    = 1'b0;
        bricks_left_d  = bricks_left_q;
        mem_addr_c     = '0;
        mem_data_c     = '0;
        mem_wren_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!holdoff) begin
                    if (init_pending_q || bus.level_start) begin
                        state_d        = S_INIT;
                        init_cnt_d     = '0;
                        init_pending_d = 1'b0;
                    end else if (bus.hit_req) begin
                        state_d    = S_HIT_RD;
                        addr_d     = brick_addr(bus.hit_col, bus.hit_row);
                        in_range_d = brick_in_range(bus.hit_col, bus.hit_row);
                    end else if (bus.draw_req) begin
                        state_d    = S_DRAW_RD;
                        addr_d     = brick_addr(bus.draw_col, bus.draw_row);
                        in_range_d = brick_in_range(bus.draw_col, bus.draw_row);
                    end
                end
            end
            S_INIT: begin
                mem_addr_c = init_cnt_q;
                mem_data_c = INIT_VAL;
                mem_wren_c = 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d       = S_IDLE;
                    init_done_d   = 1'b1;
                    bricks_left_d = FULL_COUNT;
                    initialised_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            S_HIT_RD: begin
                mem_addr_c = addr_q;
                state_d    = S_HIT_CHK;
            end
            S_HIT_CHK: begin
                mem_addr_c = addr_q;
                // An out-of-range brick reads as dead, which also suppresses the write.
                old_d      = in_range_q ? bus.mem_q : 2'd0;
                state_d    = S_HIT_WR;
            end
            S_HIT_WR: begin
                mem_addr_c   = addr_q;
                mem_data_c   = sat_dec(old_q);
                mem_wren_c   = (old_q != 2'd0);
                hit_ack_d    = 1'b1;
                hit_valid_d  = (old_q != 2'd0);
                hit_health_d = sat_dec(old_q);
                if (old_q == 2'd1 && bricks_left_q != '0) begin
                    bricks_left_d = bricks_left_q - (ADDR_W + 1)'(1);
                end
                state_d = S_IDLE;
            end
            S_DRAW_RD: begin
                mem_addr_c = addr_q;
                state_d    = S_DRAW_CHK;
            end
            S_DRAW_CHK: begin
                mem_addr_c    = addr_q;
                draw_health_d = in_range_q ? bus.mem_q : 2'd0;
                draw_ack_d    = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            init_pending_q <= 1'b0;
            initialised_q  <= 1'b0;
            init_cnt_q     <= '0;
            addr_q         <= '0;
            in_range_q     <= 1'b0;
            old_q          <= '0;
            hit_ack_q      <= 1'b0;
            hit_valid_q    <= 1'b0;
            hit_health_q   <= '0;
            draw_ack_q     <= 1'b0;
            draw_health_q  <= '0;
            init_done_q    <= 1'b0;
            bricks_left_q  <= '0;
        end else begin
            state_q        <= state_d;
            init_pending_q <= init_pending_d;
            initialised_q  <= initialised_d;
            init_cnt_q     <= init_cnt_d;
            addr_q         <= addr_d;
            in_range_q     <= in_range_d;
            old_q          <= old_d;
            hit_ack_q      <= hit_ack_d;
            hit_valid_q    <= hit_valid_d;
            hit_health_q   <= hit_health_d;
            draw_ack_q     <= draw_ack_d;
            draw_health_q  <= draw_health_d;
            init_done_q    <= init_done_d;
            bricks_left_q  <= bricks_left_d;
        end
    end

    assign bus.init_busy   = (state_q == S_INIT);
    assign bus.init_done   = init_done_q;
    assign bus.hit_ack     = hit_ack_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_health  = hit_health_q;
    assign bus.draw_ack    = draw_ack_q;
    assign bus.draw_health = draw_health_q;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_data    = mem_data_c;
    assign bus.mem_wren    = mem_wren_c;
    assign bus.bricks_left = bricks_left_q;
    assign bus.level_clear = (bricks_left_q == '0) && initialised_q && (state_q != S_INIT);

endmodule

// File: tb/tb_brick_mem_ctrl.sv
// Bench for brick_mem_ctrl: directed vector table, multi-cycle corner cases and
// randomized hits/draws against a per-brick health array model.
module tb_brick_mem_ctrl;

    localparam int GRID_W      = 8;
    localparam int GRID_H      = 4;
    localparam int COL_W       = 4;   // wide enough to present col 9
    localparam int ROW_W       = 3;   // wide enough to present row 5
    localparam int ADDR_W      = 5;
    localparam int INIT_HEALTH = 3;
    localparam int N           = GRID_W * GRID_H;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    brick_mem_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

    brick_mem_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .COL_W(COL_W), .ROW_W(ROW_W),
        .ADDR_W(ADDR_W), .INIT_HEALTH(INIT_HEALTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Single-port synchronous RAM, read data one cycle after the address.
    logic [1:0] ram [N];
    logic [1:0] ram_q = 2'd0;
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        ram_q <= ram[bus.mem_addr];
    end
    assign bus.mem_q = ram_q;

    // Reference model: health per brick.
    int health_m [N];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_draw;
        int col;
        int row;
        int e_val;
        int e_h;
        int e_left;
    } vec_t;
    vec_t tbl [12];
    int   ack_cyc [12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_left();
        int n = 0;
        for (int i = 0; i < N; i++) if (health_m[i] > 0) n++;
        return n;
    endfunction

    function automatic int all_outs();
        return int'({bus.init_busy, bus.init_done, bus.hit_ack, bus.hit_valid,
                     bus.hit_health, bus.draw_ack, bus.draw_health, bus.mem_addr,
                     bus.mem_data, bus.mem_wren, bus.bricks_left, bus.level_clear});
    endfunction

    task automatic model_fill();
        for (int i = 0; i < N; i++) health_m[i] = INIT_HEALTH;
    endtask

    // Model of one transaction: returns valid, health and whether a write happens.
    task automatic model_txn(input bit is_draw, input int col, input int row,
                             output int e_val, output int e_h, output int e_wr);
        int a;
        e_val = 0; e_h = 0; e_wr = 0;
        if (col < GRID_W && row < GRID_H) begin
            a = row * GRID_W + col;
            if (is_draw) begin
                e_h = health_m[a];
            end else if (health_m[a] > 0) begin
                health_m[a] = health_m[a] - 1;
                e_val = 1;
                e_h   = health_m[a];
                e_wr  = 1;
            end
        end
    endtask

    // Drives one request and waits (bounded) for its ack; returns at the ack negedge.
    task automatic txn(input bit is_draw, input int col, input int row,
                       output int lat, output int val, output int hlth,
                       output int wr_cnt, output int wr_addr, output int wr_data,
                       output int at_cyc);
        lat = -1; val = 0; hlth = -1; wr_cnt = 0; wr_addr = -1; wr_data = -1; at_cyc = -1;
        @(negedge clk);
        if (is_draw) begin
            bus.draw_col = COL_W'(col); bus.draw_row = ROW_W'(row); bus.draw_req = 1'b1;
        end else begin
            bus.hit_col = COL_W'(col); bus.hit_row = ROW_W'(row); bus.hit_req = 1'b1;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.mem_wren) begin
                wr_cnt++; wr_addr = int'(bus.mem_addr); wr_data = int'(bus.mem_data);
            end
            if (is_draw ? bus.draw_ack : bus.hit_ack) begin
                lat    = c;
                val    = int'(bus.hit_valid);
                hlth   = is_draw ? int'(bus.draw_health) : int'(bus.hit_health);
                at_cyc = cyc;
                break;
            end
        end
        bus.hit_req  = 1'b0;
        bus.draw_req = 1'b0;
    endtask

    task automatic run_checked(input string tag, input bit is_draw, input int col, input int row);
        int e_val, e_h, e_wr, lat, val, hlth, wc, wa, wd, ac;
        model_txn(is_draw, col, row, e_val, e_h, e_wr);
        txn(is_draw, col, row, lat, val, hlth, wc, wa, wd, ac);
        check({tag, "_lat"}, lat, is_draw ? 3 : 4);
        if (!is_draw) check({tag, "_valid"}, val, e_val);
        check({tag, "_health"}, hlth, e_h);
        check({tag, "_wr_cnt"}, wc, e_wr);
        if (e_wr != 0) begin
            check({tag, "_wr_addr"}, wa, row * GRID_W + col);
            check({tag, "_wr_data"}, wd, e_h);
        end
        check({tag, "_left"}, int'(bus.bricks_left), m_left());
        check({tag, "_clear"}, int'(bus.level_clear), int'(m_left() == 0));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat, val, hlth, wc, wa, wd, ac;
        int hit_c, draw_c, hh, dh, acks, busy_c, busy_n, done_c, dones;

        tbl[0]  = '{0, 2, 1, 1, 2, 32};
        tbl[1]  = '{0, 2, 1, 1, 1, 32};
        tbl[2]  = '{0, 2, 1, 1, 0, 31};
        tbl[3]  = '{0, 2, 1, 0, 0, 31};
        tbl[4]  = '{1, 2, 1, 0, 0, 31};
        tbl[5]  = '{1, 3, 1, 0, 3, 31};
        tbl[6]  = '{1, 9, 0, 0, 0, 31};
        tbl[7]  = '{0, 9, 0, 0, 0, 31};
        tbl[8]  = '{0, 0, 5, 0, 0, 31};
        tbl[9]  = '{1, 7, 3, 0, 3, 31};
        tbl[10] = '{0, 7, 3, 1, 2, 31};
        tbl[11] = '{1, 7, 3, 0, 2, 31};

        for (int i = 0; i < N; i++) ram[i] = 2'd0;
        bus.level_start = 1'b0;
        bus.hit_req = 1'b0;  bus.hit_col = '0;  bus.hit_row = '0;
        bus.draw_req = 1'b0; bus.draw_col = '0; bus.draw_row = '0;

        // Reset state
        @(negedge clk);
        check("reset_outs_held", all_outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outs_after", all_outs(), 0);

        // Level fill with exact cycle timing
        bus.level_start = 1'b1;
        @(negedge clk);
        bus.level_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("init_write", int'({bus.mem_wren, bus.init_busy, bus.mem_addr, bus.mem_data}),
                  int'({1'b1, 1'b1, 5'(i), 2'(INIT_HEALTH)}));
            @(negedge clk);
        end
        check("init_done_pulse", int'({bus.init_done, bus.init_busy, bus.mem_wren}), 4);
        check("init_bricks_left", int'(bus.bricks_left), N);
        check("init_level_clear", int'(bus.level_clear), 0);
        @(negedge clk);
        check("init_done_drop", int'(bus.init_done), 0);
        model_fill();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            int d0, d1, d2;
            model_txn(tbl[i].is_draw, tbl[i].col, tbl[i].row, d0, d1, d2);
            txn(tbl[i].is_draw, tbl[i].col, tbl[i].row, lat, val, hlth, wc, wa, wd, ac);
            ack_cyc[i] = ac;
            check($sformatf("vec%0d_lat", i), lat, tbl[i].is_draw ? 3 : 4);
            if (!tbl[i].is_draw) check($sformatf("vec%0d_valid", i), val, tbl[i].e_val);
            check($sformatf("vec%0d_health", i), hlth, tbl[i].e_h);
            check($sformatf("vec%0d_left", i), int'(bus.bricks_left), tbl[i].e_left);
            check($sformatf("vec%0d_wr_cnt", i), wc, int'(!tbl[i].is_draw && tbl[i].e_val != 0));
            if (!tbl[i].is_draw && tbl[i].e_val != 0) begin
                check($sformatf("vec%0d_wr_addr", i), wa, tbl[i].row * GRID_W + tbl[i].col);
                check($sformatf("vec%0d_wr_data", i), wd, tbl[i].e_h);
            end
        end
        check("hit_throughput", ack_cyc[1] - ack_cyc[0], 5);
        check("draw_throughput", ack_cyc[5] - ack_cyc[4], 4);

        // Hit and draw raised together on brick (4,2)
        @(negedge clk);
        bus.hit_col = 4'd4;  bus.hit_row = 3'd2;  bus.hit_req = 1'b1;
        bus.draw_col = 4'd4; bus.draw_row = 3'd2; bus.draw_req = 1'b1;
        hit_c = -1; draw_c = -1; hh = -1; dh = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.hit_ack)  begin hit_c = c;  hh = int'(bus.hit_health);  bus.hit_req = 1'b0;  end
            if (bus.draw_ack) begin draw_c = c; dh = int'(bus.draw_health); bus.draw_req = 1'b0; end
            if (hit_c > 0 && draw_c > 0) break;
        end
        bus.hit_req = 1'b0; bus.draw_req = 1'b0;
        health_m[2 * GRID_W + 4] = health_m[2 * GRID_W + 4] - 1;
        check("arb_hit_cycle", hit_c, 4);
        check("arb_draw_cycle", draw_c, 8);
        check("arb_hit_health", hh, 2);
        check("arb_draw_post_hit", dh, 2);

        // level_start during HIT_CHK of a hit on brick (5,3)
        @(negedge clk);
        bus.hit_col = 4'd5; bus.hit_row = 3'd3; bus.hit_req = 1'b1;
        hit_c = -1; hh = -1; acks = 0; busy_c = -1; busy_n = 0; done_c = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.level_start = (c == 2);
            if (bus.hit_ack) begin acks++; hit_c = c; hh = int'(bus.hit_health); bus.hit_req = 1'b0; end
            if (bus.init_busy) begin busy_n++; if (busy_c < 0) busy_c = c; end
            if (bus.init_done) begin done_c = c; break; end
        end
        bus.level_start = 1'b0; bus.hit_req = 1'b0;
        check("ls_hit_acks", acks, 1);
        check("ls_hit_cycle", hit_c, 4);
        check("ls_hit_health", hh, 2);
        check("ls_init_first_busy", busy_c, 6);
        check("ls_init_busy_len", busy_n, N);
        check("ls_init_done_cycle", done_c, 6 + N);
        model_fill();
        check("ls_bricks_left", int'(bus.bricks_left), N);

        // Randomized hits and draws, some out of range
        for (int i = 0; i < 120; i++) begin
            run_checked("rnd", bit'($urandom_range(0, 1)),
                        int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
        end

        // Hit every brick down to zero, plus one extra pass to probe saturation
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < GRID_H; r++)
                for (int c = 0; c < GRID_W; c++)
                    run_checked("sweep", 1'b0, c, r);
        check("clear_bricks_left", int'(bus.bricks_left), 0);
        check("clear_level_clear", int'(bus.level_clear), 1);

        // Asynchronous reset in the middle of a fill
        @(negedge clk);
        bus.level_start = 1'b1;
        @(negedge clk);
        bus.level_start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_init_busy", int'(bus.init_busy), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outs", all_outs(), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dones = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.init_done) dones++;
            if (bus.init_busy || bus.mem_wren) busy_n++;
        end
        check("abort_no_init_done", dones, 0);
        check("abort_no_activity", busy_n, 0);
        check("abort_outs", all_outs(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
